// File: rtl/vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_generator
// Purpose  : VGA 640x480@60 timing, coordinate export and colour pipeline.
//            Optional colour-bar generator enabled by VGA_SYNC_TEST_PATTERN_EN.
// Revision : 1.0
// ============================================================================
module vga_sync_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef VGA_SYNC_TEST_PATTERN_EN
    input  logic        tp_sel,
`endif
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_tick,
    output logic        frame_start,
    input  logic [23:0] rgb_in,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_H_START = H_SYNC + H_BACK;
    localparam int c_H_END   = c_H_START + H_ACTIVE;
    localparam int c_V_START = V_SYNC + V_BACK;
    localparam int c_V_END   = c_V_START + V_ACTIVE;
    localparam int c_PH_W    = $clog2(CLK_DIV);
`ifdef VGA_SYNC_TEST_PATTERN_EN
    localparam int c_BAR_W   = H_ACTIVE / 8;
    localparam int c_STG_W   = 6;
`else
    localparam int c_STG_W   = 3;
`endif
    // Stage layout: [2]=hs, [1]=vs, [0]=act, upper bits carry the bar index.
    localparam logic [c_STG_W-1:0] c_STG_RST = c_STG_W'(3'b110);

    logic [c_PH_W-1:0] r_phase;
    logic [c_PH_W-1:0] w_phase_next;
    logic              w_tick;
    logic              r_vga_clk;

    always_comb begin
        w_tick       = (r_phase == c_PH_W'(CLK_DIV - 1));
        w_phase_next = w_tick ? '0 : r_phase + 1'b1;
    end

    // vga_clk follows the phase it is entering so it stays aligned to pix_tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase   <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_phase   <= w_phase_next;
            r_vga_clk <= (w_phase_next >= c_PH_W'(CLK_DIV / 2));
        end
    end

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       w_x_wrap;
    logic       r_frame_start;

    assign w_x_wrap = (r_x == 10'(c_H_TOTAL - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && (r_x == 10'd0) && (r_y == 10'd0);
            if (w_tick) begin
                r_x <= w_x_wrap ? '0 : r_x + 10'd1;
                if (w_x_wrap) begin
                    r_y <= (r_y == 10'(c_V_TOTAL - 1)) ? '0 : r_y + 10'd1;
                end
            end
        end
    end

    logic               w_hs_raw;
    logic               w_vs_raw;
    logic               w_h_act;
    logic               w_act_raw;
    logic [c_STG_W-1:0] w_stage_in;
`ifdef VGA_SYNC_TEST_PATTERN_EN
    logic [2:0]         w_bar_raw;
`endif

    always_comb begin
        w_hs_raw  = (r_x >= 10'(H_SYNC));
        w_vs_raw  = (r_y >= 10'(V_SYNC));
        w_h_act   = (r_x >= 10'(c_H_START)) && (r_x < 10'(c_H_END));
        w_act_raw = w_h_act && (r_y >= 10'(c_V_START)) && (r_y < 10'(c_V_END));
`ifdef VGA_SYNC_TEST_PATTERN_EN
        w_bar_raw  = w_h_act ? 3'((r_x - 10'(c_H_START)) / 10'(c_BAR_W)) : 3'd0;
        w_stage_in = {w_bar_raw, w_hs_raw, w_vs_raw, w_act_raw};
`else
        w_stage_in = {w_hs_raw, w_vs_raw, w_act_raw};
`endif
    end

    logic [PIPE_LAT-1:0][c_STG_W-1:0] r_pipe;
    logic [c_STG_W-1:0]               w_stage_out;

    assign w_stage_out = r_pipe[PIPE_LAT-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe <= {PIPE_LAT{c_STG_RST}};
        end else if (w_tick) begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    logic [23:0] w_colour;

`ifdef VGA_SYNC_TEST_PATTERN_EN
    // Bar index bits map directly onto the missing primaries of the bar order.
    always_comb begin
        w_colour = rgb_in;
        if (tp_sel) begin
            w_colour = {{8{~w_stage_out[4]}}, {8{~w_stage_out[5]}}, {8{~w_stage_out[3]}}};
        end
    end
`else
    assign w_colour = rgb_in;
`endif

    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic [23:0] r_rgb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else if (w_tick) begin
            r_hs      <= w_stage_out[2];
            r_vs      <= w_stage_out[1];
            r_blank_n <= w_stage_out[0];
            r_rgb     <= w_stage_out[0] ? w_colour : 24'h0;
        end
    end

    assign pix_x       = r_x;
    assign pix_y       = r_y;
    assign pix_tick    = w_tick;
    assign frame_start = r_frame_start;
    assign vga_r       = r_rgb[23:16];
    assign vga_g       = r_rgb[15:8];
    assign vga_b       = r_rgb[7:0];
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = r_vga_clk;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_generator
// Purpose  : Self-checking bench for vga_sync_generator (three configurations).
// Revision : 1.0
// ============================================================================
module tb_vga_sync_generator;

    // Reduced geometry keeps whole frames short; instance C keeps defaults.
    localparam int S_HT = 31, S_VT = 15, S_HSY = 6, S_VSY = 2;
    localparam int S_HST = 11, S_HACT = 16, S_VST = 5, S_VACT = 8;
`ifdef VGA_SYNC_TEST_PATTERN_EN
    localparam bit TP_B = 1'b1;
`else
    localparam bit TP_B = 1'b0;
`endif

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        tick;
        logic        fs;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  a_px, a_py, b_px, b_py, c_px, c_py;
    logic        a_tk, a_fs, a_hs, a_vs, a_bn, a_sn, a_vc;
    logic        b_tk, b_fs, b_hs, b_vs, b_bn, b_sn, b_vc;
    logic        c_tk, c_fs, c_hs, c_vs, c_bn, c_sn, c_vc;
    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic [23:0] a_rgb_in = '0, b_rgb_in = '0, c_rgb_in = '0;

    vga_sync_generator #(.H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(2), .PIPE_LAT(2)) u_a (
        .clk(clk), .reset(reset),
`ifdef VGA_SYNC_TEST_PATTERN_EN
        .tp_sel(1'b0),
`endif
        .pix_x(a_px), .pix_y(a_py), .pix_tick(a_tk), .frame_start(a_fs), .rgb_in(a_rgb_in),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .vga_hs(a_hs), .vga_vs(a_vs),
        .vga_blank_n(a_bn), .vga_sync_n(a_sn), .vga_clk(a_vc));

    vga_sync_generator #(.H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(4), .PIPE_LAT(4)) u_b (
        .clk(clk), .reset(reset),
`ifdef VGA_SYNC_TEST_PATTERN_EN
        .tp_sel(1'b1),
`endif
        .pix_x(b_px), .pix_y(b_py), .pix_tick(b_tk), .frame_start(b_fs), .rgb_in(b_rgb_in),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hs(b_hs), .vga_vs(b_vs),
        .vga_blank_n(b_bn), .vga_sync_n(b_sn), .vga_clk(b_vc));

    vga_sync_generator u_c (
        .clk(clk), .reset(reset),
`ifdef VGA_SYNC_TEST_PATTERN_EN
        .tp_sel(1'b0),
`endif
        .pix_x(c_px), .pix_y(c_py), .pix_tick(c_tk), .frame_start(c_fs), .rgb_in(c_rgb_in),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b), .vga_hs(c_hs), .vga_vs(c_vs),
        .vga_blank_n(c_bn), .vga_sync_n(c_sn), .vga_clk(c_vc));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [23:0] bar_colour(int bar);
        case (bar)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Pixel source: colour for the idx-th coordinate presented since reset.
    function automatic logic [23:0] src_rgb(int idx, int ht, int vt);
        if (idx < 0) return 24'h0;
        return {8'(idx % ht), 8'((idx / ht) % vt), 8'hA5};
    endfunction

    // Everything follows from the clk count since release: k ticks done,
    // pins show the coordinate presented PIPE_LAT ticks before the last tick.
    function automatic exp_t model(int cyc, int ht, int vt, int hsy, int vsy, int hst,
                                   int hact, int vst, int vact, int d, int l, bit tp);
        exp_t e;
        int k, m, x, y;
        k      = cyc / d;
        m      = k - 1 - l;
        e.x    = 10'(k % ht);
        e.y    = 10'((k / ht) % vt);
        e.tick = ((cyc % d) == d - 1);
        e.vclk = ((cyc % d) >= d / 2);
        e.fs   = (cyc > 0) && (cyc % d == 0) && ((k - 1) % (ht * vt) == 0);
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        e.bn   = 1'b0;
        e.rgb  = 24'h0;
        if (m >= 0) begin
            x    = m % ht;
            y    = (m / ht) % vt;
            e.hs = (x >= hsy);
            e.vs = (y >= vsy);
            e.bn = (x >= hst) && (x < hst + hact) && (y >= vst) && (y < vst + vact);
            if (e.bn) e.rgb = tp ? bar_colour((x - hst) / (hact / 8)) : src_rgb(m, ht, vt);
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input exp_t e, input logic [9:0] ax, input logic [9:0] ay,
                       input logic at, input logic afs, input logic avc, input logic ahs,
                       input logic avs, input logic abn, input logic asn, input logic [23:0] argb);
        chk({nm, ".pix_x"}, 32'(ax), 32'(e.x));
        chk({nm, ".pix_y"}, 32'(ay), 32'(e.y));
        chk({nm, ".pix_tick"}, 32'(at), 32'(e.tick));
        chk({nm, ".frame_start"}, 32'(afs), 32'(e.fs));
        chk({nm, ".vga_clk"}, 32'(avc), 32'(e.vclk));
        chk({nm, ".vga_hs"}, 32'(ahs), 32'(e.hs));
        chk({nm, ".vga_vs"}, 32'(avs), 32'(e.vs));
        chk({nm, ".vga_blank_n"}, 32'(abn), 32'(e.bn));
        chk({nm, ".vga_sync_n"}, 32'(asn), 32'h0);
        chk({nm, ".rgb"}, 32'(argb), 32'(e.rgb));
    endtask

    int cyc = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    bit run1 = 1'b1;
    int a_fs1 = -1, a_fs2 = -1, b_fs1 = -1, b_fs2 = -1, a_fs_rst = -1;
    int a_hs_lo = 0, a_vs_lo = 0, a_bn_hi = 0, a_blank_rgb = 0, c_hs_lo = 0, b_vc_hi = 0;

    always @(negedge clk) begin
        cmp("a", model(cyc, S_HT, S_VT, S_HSY, S_VSY, S_HST, S_HACT, S_VST, S_VACT, 2, 2, 1'b0),
            a_px, a_py, a_tk, a_fs, a_vc, a_hs, a_vs, a_bn, a_sn, {a_r, a_g, a_b});
        cmp("b", model(cyc, S_HT, S_VT, S_HSY, S_VSY, S_HST, S_HACT, S_VST, S_VACT, 4, 4, TP_B),
            b_px, b_py, b_tk, b_fs, b_vc, b_hs, b_vs, b_bn, b_sn, {b_r, b_g, b_b});
        cmp("c", model(cyc, 800, 525, 96, 2, 144, 640, 35, 480, 2, 2, 1'b0),
            c_px, c_py, c_tk, c_fs, c_vc, c_hs, c_vs, c_bn, c_sn, {c_r, c_g, c_b});

        if (run1) begin
            // Hand-computed pins: x=11,y=5 is coordinate index 166.
            if (cyc == 336) chk("a.blank_before_first_pixel", 32'(a_bn), 32'h0);
            if (cyc == 338) chk("a.first_pixel_rgb", 32'({a_r, a_g, a_b}), 32'h0B05A5);
            if (cyc == 683) chk("b.blank_before_rise", 32'(b_bn), 32'h0);
            if (cyc == 684) chk("b.blank_rise", 32'(b_bn), 32'h1);
`ifdef VGA_SYNC_TEST_PATTERN_EN
            if (cyc == 684) chk("b.bar_white", 32'({b_r, b_g, b_b}), 32'hFFFFFF);
            if (cyc == 692) chk("b.bar_yellow", 32'({b_r, b_g, b_b}), 32'hFFFF00);
            if (cyc == 732) chk("b.bar_blue", 32'({b_r, b_g, b_b}), 32'h0000FF);
            if (cyc == 744) chk("b.bar_black", 32'({b_r, b_g, b_b, b_bn}), 32'h1);
`else
            if (cyc == 684) chk("b.first_pixel_rgb", 32'({b_r, b_g, b_b}), 32'h0B05A5);
`endif
            if (a_fs) begin
                if (a_fs1 < 0) a_fs1 = cyc;
                else if (a_fs2 < 0) a_fs2 = cyc;
            end
            if (b_fs) begin
                if (b_fs1 < 0) b_fs1 = cyc;
                else if (b_fs2 < 0) b_fs2 = cyc;
            end
            if (cyc > 0 && cyc % 2 == 0 && cyc / 2 >= 500 && cyc / 2 < 965) begin
                a_hs_lo     += (a_hs == 1'b0) ? 1 : 0;
                a_vs_lo     += (a_vs == 1'b0) ? 1 : 0;
                a_bn_hi     += (a_bn == 1'b1) ? 1 : 0;
                a_blank_rgb += (a_bn == 1'b0 && {a_r, a_g, a_b} != 24'h0) ? 1 : 0;
            end
            if (cyc > 0 && cyc % 2 == 0 && cyc / 2 >= 1000 && cyc / 2 < 1800)
                c_hs_lo += (c_hs == 1'b0) ? 1 : 0;
            if (cyc >= 100 && cyc < 200) b_vc_hi += (b_vc == 1'b1) ? 1 : 0;
        end else if (a_fs && a_fs_rst < 0) begin
            a_fs_rst = cyc;
        end

        // Pixel sources answer PIPE_LAT ticks behind the coordinates.
        a_rgb_in = src_rgb(cyc / 2 - 2, S_HT, S_VT);
        b_rgb_in = src_rgb(cyc / 4 - 4, S_HT, S_VT);
        c_rgb_in = src_rgb(cyc / 2 - 2, 800, 525);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("c.reset_hs", 32'(c_hs), 32'h1);
        chk("c.reset_blank_n", 32'(c_bn), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4000) @(posedge clk);
        #1;
        chk("c.pre_reset_x", 32'(c_px), 32'd400);
        chk("c.pre_reset_y", 32'(c_py), 32'd2);
        chk("b.pre_reset_hs", 32'(b_hs), 32'h0);
        run1  = 1'b0;
        reset = 1'b0;
        #1;
        chk("c.async_x", 32'(c_px), 32'h0);
        chk("c.async_y", 32'(c_py), 32'h0);
        chk("b.async_hs", 32'(b_hs), 32'h1);
        chk("b.async_x", 32'(b_px), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (1000) @(posedge clk);
        @(negedge clk);

        chk("a.frame_period", 32'(a_fs2 - a_fs1), 32'd930);
        chk("b.frame_period", 32'(b_fs2 - b_fs1), 32'd1860);
        chk("a.hs_low_ticks", 32'(a_hs_lo), 32'd90);
        chk("a.vs_low_ticks", 32'(a_vs_lo), 32'd62);
        chk("a.visible_ticks", 32'(a_bn_hi), 32'd128);
        chk("a.blanked_colour", 32'(a_blank_rgb), 32'd0);
        chk("c.hs_low_per_line", 32'(c_hs_lo), 32'd96);
        chk("b.vga_clk_high", 32'(b_vc_hi), 32'd50);
        chk("a.first_fs_after_reset", 32'(a_fs_rst), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
